// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Operands are registered toward the ALU; the ALU result is registered per requester.
module alu_share_arbiter #(
   parameter int XLEN         = 32,
   parameter int STALL_CYCLES = 0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req0_valid_i,
   output logic            req0_ready_o,
   input  logic [3:0]      req0_ctrl_i,
   input  logic [XLEN-1:0] req0_a_i,
   input  logic [XLEN-1:0] req0_b_i,
   input  logic            req1_valid_i,
   output logic            req1_ready_o,
   input  logic [3:0]      req1_ctrl_i,
   input  logic [XLEN-1:0] req1_a_i,
   input  logic [XLEN-1:0] req1_b_i,
   output logic            rsp0_valid_o,
   input  logic            rsp0_ready_i,
   output logic [XLEN-1:0] rsp0_result_o,
   output logic            rsp1_valid_o,
   input  logic            rsp1_ready_i,
   output logic [XLEN-1:0] rsp1_result_o,
   output logic [3:0]      alu_control_o,
   output logic [XLEN-1:0] alu_a_o,
   output logic [XLEN-1:0] alu_b_o,
   input  logic [XLEN-1:0] alu_result_i,
   output logic            busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] STALL_INIT = 2'(STALL_CYCLES);

   state_t          state_q, state_d;
   logic            rr_ptr_q, rr_ptr_d;
   logic            owner_q, owner_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [3:0]      alu_ctrl_q, alu_ctrl_d;
   logic [XLEN-1:0] alu_a_q, alu_a_d;
   logic [XLEN-1:0] alu_b_q, alu_b_d;
   logic [XLEN-1:0] rsp0_result_q, rsp0_result_d;
   logic [XLEN-1:0] rsp1_result_q, rsp1_result_d;

   logic ptr_valid, other_valid, grant, grant_valid, accept, rsp_hs;

   // A transfer happens on a rising edge where valid and ready are both high.
   // Request ready is combinational on the requesters' valids while IDLE.
   always_comb begin
      ptr_valid   = rr_ptr_q ? req1_valid_i : req0_valid_i;
      other_valid = rr_ptr_q ? req0_valid_i : req1_valid_i;
      grant       = ptr_valid ? rr_ptr_q : ~rr_ptr_q;
      grant_valid = ptr_valid | other_valid;
      accept      = rst_ni & (state_q == IDLE) & grant_valid;
      rsp_hs      = (state_q == RESP) & (owner_q ? rsp1_ready_i : rsp0_ready_i);
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      owner_d       = owner_q;
      cnt_d         = cnt_q;
      alu_ctrl_d    = alu_ctrl_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      rsp0_result_d = rsp0_result_q;
      rsp1_result_d = rsp1_result_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               alu_ctrl_d = grant ? req1_ctrl_i : req0_ctrl_i;
               alu_a_d    = grant ? req1_a_i : req0_a_i;
               alu_b_d    = grant ? req1_b_i : req0_b_i;
               owner_d    = grant;
               cnt_d      = STALL_INIT;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q != 2'd0) begin
               cnt_d = cnt_q - 2'd1;
            end else begin
               if (owner_q) rsp1_result_d = alu_result_i;
               else         rsp0_result_d = alu_result_i;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_hs) begin
               rr_ptr_d = ~owner_q;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         rr_ptr_q      <= 1'b0;
         owner_q       <= 1'b0;
         cnt_q         <= 2'd0;
         alu_ctrl_q    <= 4'd0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         rsp0_result_q <= '0;
         rsp1_result_q <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         owner_q       <= owner_d;
         cnt_q         <= cnt_d;
         alu_ctrl_q    <= alu_ctrl_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         rsp0_result_q <= rsp0_result_d;
         rsp1_result_q <= rsp1_result_d;
      end
   end

   assign req0_ready_o  = accept & ~grant;
   assign req1_ready_o  = accept & grant;
   assign rsp0_valid_o  = (state_q == RESP) & ~owner_q;
   assign rsp1_valid_o  = (state_q == RESP) & owner_q;
   assign rsp0_result_o = rsp0_result_q;
   assign rsp1_result_o = rsp1_result_q;
   assign alu_control_o = alu_ctrl_q;
   assign alu_a_o       = alu_a_q;
   assign alu_b_o       = alu_b_q;
   assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (0 and 2 stall cycles) share one stimulus
// stream and are checked every cycle against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
   logic [3:0]  req0_ctrl, req1_ctrl;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;

   logic        req0_ready_w[2], req1_ready_w[2], rsp0_valid_w[2], rsp1_valid_w[2], busy_w[2];
   logic [31:0] rsp0_result_w[2], rsp1_result_w[2], alu_a_w[2], alu_b_w[2], alu_res_w[2];
   logic [3:0]  alu_ctrl_w[2];

   int n_vec  = 0;
   int n_miss = 0;

   // RV32 ALU sitting behind each arbiter; codes 10..15 return 0.
   function automatic logic [31:0] alu_fn(logic [3:0] c, logic [31:0] a, logic [31:0] b);
      case (c)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a << b[4:0];
         4'd3: return {31'd0, $signed(a) < $signed(b)};
         4'd4: return {31'd0, a < b};
         4'd5: return a ^ b;
         4'd6: return a >> b[4:0];
         4'd7: return $unsigned($signed(a) >>> b[4:0]);
         4'd8: return a | b;
         4'd9: return a & b;
         default: return 32'd0;
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      alu_share_arbiter #(.XLEN(32), .STALL_CYCLES(2 * g)) u_dut (
         .clk_i        (clk),
         .rst_ni       (rst_n),
         .req0_valid_i (req0_valid),
         .req0_ready_o (req0_ready_w[g]),
         .req0_ctrl_i  (req0_ctrl),
         .req0_a_i     (req0_a),
         .req0_b_i     (req0_b),
         .req1_valid_i (req1_valid),
         .req1_ready_o (req1_ready_w[g]),
         .req1_ctrl_i  (req1_ctrl),
         .req1_a_i     (req1_a),
         .req1_b_i     (req1_b),
         .rsp0_valid_o (rsp0_valid_w[g]),
         .rsp0_ready_i (rsp0_ready),
         .rsp0_result_o(rsp0_result_w[g]),
         .rsp1_valid_o (rsp1_valid_w[g]),
         .rsp1_ready_i (rsp1_ready),
         .rsp1_result_o(rsp1_result_w[g]),
         .alu_control_o(alu_ctrl_w[g]),
         .alu_a_o      (alu_a_w[g]),
         .alu_b_o      (alu_b_w[g]),
         .alu_result_i (alu_res_w[g]),
         .busy_o       (busy_w[g])
      );
      assign alu_res_w[g] = alu_fn(alu_ctrl_w[g], alu_a_w[g], alu_b_w[g]);
   end

   // ---------------- scoreboard helpers ----------------
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: actual %h, required %h", name, act, exp);
      end
   endtask

   task automatic chk1(string name, logic act, logic exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: actual %b, required %b", name, act, exp);
      end
   endtask

   // ---------------- transaction model ----------------
   // Each instance: either idle, or holding one accepted op with the edge index at which it
   // was accepted; its response shows 1+stall edges later and leaves on the rsp handshake.
   int          cyc = 0;
   bit          m_busy[2], m_owner[2], m_ptr[2];
   int          m_acc[2];
   logic [3:0]  m_ctl[2];
   logic [31:0] m_a[2], m_b[2];
   logic [31:0] m_res[2][2];

   function automatic int exp_grant(int k);
      if (!rst_n || m_busy[k]) return -1;
      if (m_ptr[k] == 1'b0) begin
         if (req0_valid) return 0;
         if (req1_valid) return 1;
      end else begin
         if (req1_valid) return 1;
         if (req0_valid) return 0;
      end
      return -1;
   endfunction

   function automatic bit exp_rsp(int k, int side);
      return m_busy[k] && (cyc - m_acc[k] >= 1 + 2 * k) && (int'(m_owner[k]) == side);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_busy[k]  <= 1'b0;
            m_owner[k] <= 1'b0;
            m_ptr[k]   <= 1'b0;
            m_acc[k]   <= 0;
            m_ctl[k]   <= 4'd0;
            m_a[k]     <= 32'd0;
            m_b[k]     <= 32'd0;
            m_res[k][0] <= 32'd0;
            m_res[k][1] <= 32'd0;
         end
      end else begin
         cyc <= cyc + 1;
         for (int k = 0; k < 2; k++) begin
            int gsel;
            gsel = exp_grant(k);
            if (!m_busy[k]) begin
               if (gsel >= 0) begin
                  m_busy[k]  <= 1'b1;
                  m_acc[k]   <= cyc + 1;
                  m_owner[k] <= (gsel == 1);
                  m_ctl[k]   <= (gsel == 1) ? req1_ctrl : req0_ctrl;
                  m_a[k]     <= (gsel == 1) ? req1_a : req0_a;
                  m_b[k]     <= (gsel == 1) ? req1_b : req0_b;
               end
            end else if (cyc - m_acc[k] >= 1 + 2 * k) begin
               if (m_owner[k] ? rsp1_ready : rsp0_ready) begin
                  m_busy[k] <= 1'b0;
                  m_ptr[k]  <= ~m_owner[k];
               end
            end else if (cyc + 1 == m_acc[k] + 1 + 2 * k) begin
               m_res[k][m_owner[k]] <= alu_fn(m_ctl[k], m_a[k], m_b[k]);
            end
         end
      end
   end

   // Compare process: every falling edge, both instances, all outputs.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk1($sformatf("i%0d req0_ready", k), req0_ready_w[k], exp_grant(k) == 0);
            chk1($sformatf("i%0d req1_ready", k), req1_ready_w[k], exp_grant(k) == 1);
            chk1($sformatf("i%0d rsp0_valid", k), rsp0_valid_w[k], exp_rsp(k, 0));
            chk1($sformatf("i%0d rsp1_valid", k), rsp1_valid_w[k], exp_rsp(k, 1));
            chk1($sformatf("i%0d busy", k), busy_w[k], m_busy[k]);
            chk($sformatf("i%0d alu_ctrl", k), {28'd0, alu_ctrl_w[k]}, {28'd0, m_ctl[k]});
            chk($sformatf("i%0d alu_a", k), alu_a_w[k], m_a[k]);
            chk($sformatf("i%0d alu_b", k), alu_b_w[k], m_b[k]);
            chk($sformatf("i%0d rsp0_result", k), rsp0_result_w[k], m_res[k][0]);
            chk($sformatf("i%0d rsp1_result", k), rsp1_result_w[k], m_res[k][1]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op0(logic [3:0] c, logic [31:0] a, logic [31:0] b);
      req0_valid = 1'b1; req0_ctrl = c; req0_a = a; req0_b = b;
   endtask

   task automatic op1(logic [3:0] c, logic [31:0] a, logic [31:0] b);
      req1_valid = 1'b1; req1_ctrl = c; req1_a = a; req1_b = b;
   endtask

   // Called at a falling edge; waits (bounded) for a response, then checks its value.
   task automatic wait_rsp(int k, int side, logic [31:0] exp);
      bit seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (side == 1 ? rsp1_valid_w[k] : rsp0_valid_w[k]) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk1($sformatf("i%0d rsp%0d arrives", k, side), seen, 1'b1);
      if (seen) chk($sformatf("i%0d rsp%0d value", k, side),
                    side == 1 ? rsp1_result_w[k] : rsp0_result_w[k], exp);
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy_w[0] && !busy_w[1]) begin
            idle = 1'b1;
            break;
         end
      end
      chk1("drain to idle", idle, 1'b1);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 4))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- directed + random stimulus ----------------
   initial begin
      bit both;
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_ctrl = 4'd0; req1_ctrl = 4'd0;
      req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b0;
      op0(4'd1, 32'd5, 32'd7);
      op1(4'd7, 32'h8000_0000, 32'd4);

      // reset with requests pending
      repeat (3) tick();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk1($sformatf("i%0d reset req0_ready", k), req0_ready_w[k], 1'b0);
         chk1($sformatf("i%0d reset busy", k), busy_w[k], 1'b0);
         chk($sformatf("i%0d reset alu_a", k), alu_a_w[k], 32'd0);
      end

      // contention: req0 wins first out of reset
      tick(); rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk1($sformatf("i%0d contend req0_ready", k), req0_ready_w[k], 1'b1);
         chk1($sformatf("i%0d contend req1_ready", k), req1_ready_w[k], 1'b0);
      end
      tick(); req0_valid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk($sformatf("i%0d sub alu_a", k), alu_a_w[k], 32'd5);
      wait_rsp(0, 0, 32'hFFFF_FFFE);
      wait_rsp(1, 0, 32'hFFFF_FFFE);

      // req1 served next; rsp1 back-pressured
      both = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rsp1_valid_w[0] && rsp1_valid_w[1]) begin
            both = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk1("both rsp1 valid", both, 1'b1);
      tick(); req1_valid = 1'b0; op0(4'd0, 32'd1, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk1($sformatf("i%0d hold rsp1_valid", k), rsp1_valid_w[k], 1'b1);
            chk($sformatf("i%0d hold rsp1_result", k), rsp1_result_w[k], 32'hF800_0000);
            chk1($sformatf("i%0d hold req0_ready", k), req0_ready_w[k], 1'b0);
         end
      end
      tick(); rsp1_ready = 1'b1; op1(4'd5, 32'd3, 32'd5);
      tick(); rsp1_ready = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk1($sformatf("i%0d rr req0_ready", k), req0_ready_w[k], 1'b1);
         chk1($sformatf("i%0d rr req1_ready", k), req1_ready_w[k], 1'b0);
      end
      tick(); req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      wait_idle();
      for (int k = 0; k < 2; k++) chk($sformatf("i%0d add1 result", k), rsp0_result_w[k], 32'd2);

      // single ADD with overflow into bit 31
      tick(); op0(4'd0, 32'h7FFF_FFFF, 32'd1); rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk1($sformatf("i%0d add req0_ready", k), req0_ready_w[k], 1'b1);
      tick(); req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom;
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk($sformatf("i%0d add alu_a", k), alu_a_w[k], 32'h7FFF_FFFF);
      chk1("i0 add rsp0_valid early", rsp0_valid_w[0], 1'b0);
      tick(); @(negedge clk);
      chk1("i0 add rsp0_valid", rsp0_valid_w[0], 1'b1);
      chk("i0 add result", rsp0_result_w[0], 32'h8000_0000);
      chk1("i1 add rsp0_valid early", rsp0_valid_w[1], 1'b0);
      tick(); tick(); @(negedge clk);
      chk1("i1 add rsp0_valid", rsp0_valid_w[1], 1'b1);
      chk("i1 add result", rsp0_result_w[1], 32'h8000_0000);
      chk1("i0 add rsp0_valid held", rsp0_valid_w[0], 1'b1);
      tick(); rsp0_ready = 1'b1;
      wait_idle();

      // SLTU on the stalled instance: operands held three cycles
      tick(); op1(4'd4, 32'd1, 32'hFFFF_FFFF); rsp1_ready = 1'b0;
      @(negedge clk);
      chk1("i1 sltu req1_ready", req1_ready_w[1], 1'b1);
      tick(); req1_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("i1 sltu alu_ctrl", {28'd0, alu_ctrl_w[1]}, 32'd4);
         chk("i1 sltu alu_b", alu_b_w[1], 32'hFFFF_FFFF);
         chk1("i1 sltu rsp1_valid early", rsp1_valid_w[1], 1'b0);
         tick();
      end
      @(negedge clk);
      chk1("i1 sltu rsp1_valid", rsp1_valid_w[1], 1'b1);
      chk("i1 sltu result", rsp1_result_w[1], 32'd1);
      tick(); rsp1_ready = 1'b1;
      wait_idle();

      // reset while the op is in EXEC, then a fresh XOR
      tick(); op0(4'd9, 32'hFFFF_0000, 32'h00FF_FF00);
      tick(); req0_valid = 1'b0; rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk1($sformatf("i%0d rst rsp0_valid", k), rsp0_valid_w[k], 1'b0);
            chk1($sformatf("i%0d rst busy", k), busy_w[k], 1'b0);
            chk($sformatf("i%0d rst alu_a", k), alu_a_w[k], 32'd0);
         end
      end
      tick(); rst_n = 1'b1;
      tick(); op1(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00); rsp1_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk1($sformatf("i%0d xor req1_ready", k), req1_ready_w[k], 1'b1);
      tick(); req1_valid = 1'b0;
      @(negedge clk);
      wait_rsp(0, 1, 32'h0FF0_0FF0);
      wait_rsp(1, 1, 32'h0FF0_0FF0);
      wait_idle();

      // randomized traffic, including drops of valid and occasional resets
      for (int i = 0; i < 600; i++) begin
         tick();
         rst_n      = ($urandom_range(0, 199) != 0);
         req0_valid = ($urandom_range(0, 99) < 55);
         req1_valid = ($urandom_range(0, 99) < 55);
         req0_ctrl  = 4'($urandom_range(0, 15));
         req1_ctrl  = 4'($urandom_range(0, 15));
         req0_a     = rnd_operand();
         req0_b     = rnd_operand();
         req1_a     = rnd_operand();
         req1_b     = rnd_operand();
         rsp0_ready = ($urandom_range(0, 99) < 70);
         rsp1_ready = ($urandom_range(0, 99) < 70);
      end
      tick();
      rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
      $fatal(1, "watchdog");
   end

endmodule
